// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM write controller.
package cam_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned ADDR_WIDTH_DEF = 2;

   // Erase-RAM content after its own reset; a returned old key equal to this means "slot unused".
   localparam logic [DATA_WIDTH_DEF-1:0] CAM_EMPTY_KEY = 8'h00;

   // Cycles from er_write to the er_erase response pulse.
   localparam int unsigned ER_RSP_LATENCY = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      WAIT   = 3'd2,
      ERASE  = 3'd3,
      WRITE  = 3'd4
   } state_e;

endpackage

// File: rtl/cam_write_ctrl.sv
// Key-write sequencer: swaps the key in the erase RAM, clears the old key from the CAM, sets the new one.
// Optional WAIT timeout with err_o pulse when CAM_WRITE_CTRL_TIMEOUT_EN is defined.
module cam_write_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int unsigned           ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] EMPTY_KEY      = DATA_WIDTH'(CAM_EMPTY_KEY),
   parameter int unsigned           TIMEOUT_CYCLES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic                  done_o,
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
   output logic                  err_o,
`endif
   output logic                  er_write_o,
   output logic [ADDR_WIDTH-1:0] er_addr_o,
   output logic [DATA_WIDTH-1:0] er_data_in_o,
   input  logic [DATA_WIDTH-1:0] er_data_out_i,
   input  logic                  er_erase_i,
   output logic                  cam_clr_o,
   output logic                  cam_set_o,
   output logic [ADDR_WIDTH-1:0] cam_addr_o,
   output logic [DATA_WIDTH-1:0] cam_key_o
);

   if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("cam_write_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

   state_e                  state_q;
   logic                    req_ready_q;
   logic                    done_q;
   logic                    er_write_q;
   logic                    cam_clr_q;
   logic                    cam_set_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   key_q;
   logic [DATA_WIDTH-1:0]   cam_key_q;
   logic                    accept_s;

`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
   localparam int unsigned        TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0]              tmo_cnt_q;
   logic                          err_q;
`endif

   assign accept_s = req_valid_i & req_ready_q;

   // Request sequencer: state, registered strobes and the latched address/keys.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         done_q      <= 1'b0;
         er_write_q  <= 1'b0;
         cam_clr_q   <= 1'b0;
         cam_set_q   <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         key_q       <= {DATA_WIDTH{1'b0}};
         cam_key_q   <= {DATA_WIDTH{1'b0}};
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
         tmo_cnt_q   <= {TMO_W{1'b0}};
         err_q       <= 1'b0;
`endif
      end else begin
         done_q     <= 1'b0;
         er_write_q <= 1'b0;
         cam_clr_q  <= 1'b0;
         cam_set_q  <= 1'b0;
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  addr_q      <= req_addr_i;
                  key_q       <= req_data_i;
                  er_write_q  <= 1'b1;
                  req_ready_q <= 1'b0;
                  state_q     <= LOOKUP;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            LOOKUP: begin
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
               tmo_cnt_q <= {TMO_W{1'b0}};
`endif
               state_q <= WAIT;
            end
            WAIT: begin
               // cam_key_q doubles as the captured old key for the clear.
               if (er_erase_i) begin
                  if (er_data_out_i == EMPTY_KEY) begin
                     cam_set_q <= 1'b1;
                     cam_key_q <= key_q;
                     done_q    <= 1'b1;
                     state_q   <= WRITE;
                  end else begin
                     cam_clr_q <= 1'b1;
                     cam_key_q <= er_data_out_i;
                     state_q   <= ERASE;
                  end
               end
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
               else if (tmo_cnt_q == TMO_LAST) begin
                  err_q       <= 1'b1;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
               end
`endif
            end
            ERASE: begin
               cam_set_q <= 1'b1;
               cam_key_q <= key_q;
               done_q    <= 1'b1;
               state_q   <= WRITE;
            end
            WRITE: begin
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               req_ready_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign done_o       = done_q;
   assign er_write_o   = er_write_q;
   assign er_addr_o    = addr_q;
   assign er_data_in_o = key_q;
   assign cam_clr_o    = cam_clr_q;
   assign cam_set_o    = cam_set_q;
   assign cam_addr_o   = addr_q;
   assign cam_key_o    = cam_key_q;
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
   assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_cam_write_ctrl.sv
// Scoreboard bench for cam_write_ctrl with a behavioural erase RAM (2-cycle response).
module tb_cam_write_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;

   typedef struct packed {
      logic          is_set;
      logic [AW-1:0] addr;
      logic [DW-1:0] key;
   } cam_op_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_data = '0;
   logic          done;
   logic          err;
   logic          er_write;
   logic [AW-1:0] er_addr;
   logic [DW-1:0] er_data_in;
   logic [DW-1:0] er_data_out;
   logic          er_erase;
   logic          cam_clr;
   logic          cam_set;
   logic [AW-1:0] cam_addr;
   logic [DW-1:0] cam_key;

   int      checks = 0;
   int      errors = 0;
   cam_op_t exp_q[$];
   logic [DW-1:0] shadow [4];
   bit      er_mute = 1'b0;

   always #5 clk = ~clk;

   cam_write_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_addr_i    (req_addr),
      .req_data_i    (req_data),
      .done_o        (done),
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
      .err_o         (err),
`endif
      .er_write_o    (er_write),
      .er_addr_o     (er_addr),
      .er_data_in_o  (er_data_in),
      .er_data_out_i (er_data_out),
      .er_erase_i    (er_erase),
      .cam_clr_o     (cam_clr),
      .cam_set_o     (cam_set),
      .cam_addr_o    (cam_addr),
      .cam_key_o     (cam_key)
   );
`ifndef CAM_WRITE_CTRL_TIMEOUT_EN
   assign err = 1'b0;
`endif

   // Erase RAM model: swap on er_write, old key returned with er_erase two cycles later.
   logic          p_v;
   logic [DW-1:0] p_d;
   logic [DW-1:0] mem [4];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         p_v <= 1'b0; p_d <= '0; er_erase <= 1'b0; er_data_out <= '0;
      end else begin
         er_erase    <= p_v & ~er_mute;
         er_data_out <= p_d;
         p_v         <= er_write;
         if (er_write) begin
            p_d          <= mem[er_addr];
            mem[er_addr] <= er_data_in;
         end
      end
   end

   // CAM-side monitor: every clear/set must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      cam_op_t e;
      if (!rst) begin
         checks++;
         if ((er_write && (cam_clr || cam_set)) || (cam_clr && cam_set)) begin
            errors++;
            $display("FAIL onehot: er_write=%0b cam_clr=%0b cam_set=%0b (required at most one)", er_write, cam_clr, cam_set);
         end
         if (cam_clr || cam_set) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL cam_unexpected: clr=%0b set=%0b addr=%0d key=%h (required no CAM strobe)", cam_clr, cam_set, cam_addr, cam_key);
            end else begin
               e = exp_q.pop_front();
               if ({cam_set, cam_addr, cam_key, done} !== {e.is_set, e.addr, e.key, e.is_set}) begin
                  errors++;
                  $display("FAIL cam_op: set=%0b addr=%0d key=%h done=%0b (required set=%0b addr=%0d key=%h done=%0b)",
                           cam_set, cam_addr, cam_key, done, e.is_set, e.addr, e.key, e.is_set);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_timeout: req_ready=%b (required 1 within 20 cycles)", req_ready);
      end
   endtask

   task automatic run_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep, output int rdy_wait);
      cam_op_t op;
      int      lat;
      int      k;
      bit      erase;
      erase = (shadow[a] != '0);
      lat   = erase ? 5 : 4;
      if (erase) begin
         op.is_set = 1'b0; op.addr = a; op.key = shadow[a];
         exp_q.push_back(op);
      end
      op.is_set = 1'b1; op.addr = a; op.key = d;
      exp_q.push_back(op);
      shadow[a] = d;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      wait_ready(rdy_wait);
      @(posedge clk);
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
      k = 1;
      checks++;
      if ({er_write, er_addr, er_data_in} !== {1'b1, a, d}) begin
         errors++;
         $display("FAIL lookup: er_write=%0b addr=%0d data=%h (required 1 %0d %h)", er_write, er_addr, er_data_in, a, d);
      end
      while (done !== 1'b1 && k < 12) begin
         checks++;
         if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_busy: req_ready=%b at cycle %0d (required 0)", req_ready, k);
         end
         if (cam_clr === 1'b1) begin
            checks++;
            if (k != 4) begin
               errors++;
               $display("FAIL clr_cycle: cam_clr at cycle %0d (required 4)", k);
            end
         end
         @(negedge clk);
         k++;
      end
      checks++;
      if (done !== 1'b1 || k != lat) begin
         errors++;
         $display("FAIL latency: done=%b at cycle %0d (required done at cycle %0d)", done, k, lat);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ready, done, er_write, cam_clr, cam_set, err, cam_addr, cam_key, er_addr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b done=%b erw=%b clr=%b set=%b err=%b caddr=%h key=%h eaddr=%h (required all 0)",
                  req_ready, done, er_write, cam_clr, cam_set, err, cam_addr, cam_key, er_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: req_ready=%b after release (required 1)", req_ready);
      end
   endtask

   task automatic test_first_write;
      int n;
      run_req(2'd1, 8'h5A, 1'b0, n);
      run_req(2'd1, 8'h3C, 1'b0, n);
   endtask

   task automatic test_same_key;
      int n;
      run_req(2'd2, 8'h77, 1'b0, n);
      run_req(2'd2, 8'h77, 1'b0, n);
   endtask

   task automatic test_back_to_back;
      int n;
      run_req(2'd0, 8'h11, 1'b1, n);
      run_req(2'd0, 8'h22, 1'b0, n);
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL b2b_accept: ready seen %0d cycles after done (required 1)", n);
      end
   endtask

   task automatic test_reset_mid_erase;
      cam_op_t op;
      int      n;
      int      k;
      run_req(2'd3, 8'h44, 1'b0, n);
      op.is_set = 1'b0; op.addr = 2'd3; op.key = 8'h44;
      exp_q.push_back(op);
      req_addr = 2'd3; req_data = 8'h66; req_valid = 1'b1;
      wait_ready(n);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      k = 1;
      while (cam_clr !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (cam_clr !== 1'b1 || k != 4) begin
         errors++;
         $display("FAIL mid_erase_reach: cam_clr=%b at cycle %0d (required 1 at cycle 4)", cam_clr, k);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({req_ready, done, er_write, cam_clr, cam_set} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset_strobes: ready=%b done=%b erw=%b clr=%b set=%b (required all 0)",
                  req_ready, done, er_write, cam_clr, cam_set);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] = '0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_ready: req_ready=%b (required 1)", req_ready);
      end
      repeat (6) @(negedge clk);
   endtask

`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      int k;
      er_mute = 1'b1;
      req_addr = 2'd0; req_data = 8'h99; req_valid = 1'b1;
      wait_ready(n);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      shadow[0] = 8'h99;
      k = 1;
      while (err !== 1'b1 && k < 12) begin
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done: done=%b at cycle %0d (required 0)", done, k);
         end
         @(negedge clk);
         k++;
      end
      checks++;
      if (err !== 1'b1 || k != 6 || req_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL timeout_err: err=%b ready=%b done=%b at cycle %0d (required err=1 ready=1 done=0 at cycle 6)",
                  err, req_ready, done, k);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: err=%b (required 0 after one cycle)", err);
      end
      er_mute = 1'b0;
      run_req(2'd0, 8'h12, 1'b0, n);
   endtask
`else
   task automatic test_wait_hold;
      int n;
      er_mute = 1'b1;
      req_addr = 2'd0; req_data = 8'h99; req_valid = 1'b1;
      wait_ready(n);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if ({req_ready, done} !== 2'b00) begin
            errors++;
            $display("FAIL wait_hold: ready=%b done=%b (required both 0 while waiting)", req_ready, done);
         end
      end
      #1 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      er_mute = 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] = '0;
      @(negedge clk);
      run_req(2'd0, 8'h12, 1'b0, n);
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) shadow[i] = '0;
      test_reset;
      test_first_write;
      test_same_key;
      test_back_to_back;
      test_reset_mid_erase;
`ifdef CAM_WRITE_CTRL_TIMEOUT_EN
      test_timeout;
`else
      test_wait_hold;
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d CAM ops outstanding (required 0)", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_write_ctrl.md
Name: cam_write_ctrl

Overview:
- Sequences every key write into the CAM.
- For each accepted request it reads back and replaces the previous key held at the target address in the erase RAM, clears that old key from the CAM, then sets the new key.
- It sits between the host write port and the erase-RAM/CAM pair, and is the only master of both.

Parameters:
- DATA_WIDTH, 8, key width; matches the erase RAM and the CAM.
- ADDR_WIDTH, 2, CAM/erase-RAM address width.
- EMPTY_KEY, 0, value the erase RAM holds after reset. A returned old key equal to this value means the slot was unused.
- TIMEOUT_CYCLES, 4, maximum cycles WAIT may last before an error. Used only when the optional feature is enabled.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host write request.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_addr  in  ADDR_WIDTH  target slot.
- req_data  in  DATA_WIDTH  new key.
- done  out  1  one-cycle pulse when a request completes.
- er_write  out  1  write strobe to the erase RAM.
- er_addr  out  ADDR_WIDTH  erase-RAM address.
- er_data_in  out  DATA_WIDTH  new key to the erase RAM.
- er_data_out  in  DATA_WIDTH  old key returned by the erase RAM.
- er_erase  in  1  erase-RAM response pulse; arrives two cycles after er_write.
- cam_clr  out  1  clear strobe for cam_key at cam_addr.
- cam_set  out  1  set strobe for cam_key at cam_addr.
- cam_addr  out  ADDR_WIDTH  CAM address.
- cam_key  out  DATA_WIDTH  key for the clear or set operation.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - req_ready=0 while rst is high; req_ready=1 in the first cycle after release.
  - done, er_write, cam_clr and cam_set = 0.
  - Address/key registers = 0.
- States: IDLE, LOOKUP, WAIT, ERASE, WRITE.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch req_addr/req_data and go to LOOKUP.
  - Only one request is accepted per handshake; req_valid is ignored outside IDLE.
- LOOKUP, exactly 1 cycle:
  - er_write=1, er_addr=latched addr, er_data_in=latched key.
  - Next state is WAIT.
- WAIT:
  - All strobes low.
  - When er_erase=1, capture er_data_out as old_key in the same cycle.
  - If old_key==EMPTY_KEY, go to WRITE; otherwise go to ERASE.
  - Nominal dwell is 2 cycles (er_erase arrives at LOOKUP+2).
- ERASE, 1 cycle:
  - cam_clr=1, cam_addr=latched addr, cam_key=old_key.
  - Next state is WRITE.
- WRITE, 1 cycle:
  - cam_set=1, cam_addr=latched addr, cam_key=new key.
  - done=1 in this cycle; next state is IDLE.
- Outputs are registered, one-hot strobes: cam_clr and cam_set are never high together; er_write is never high together with either.
- Latency from handshake to done: 5 cycles with an erase, 4 cycles when the slot was empty. The next request is accepted in the cycle after done.
- Same key rewritten to the same address: it still erases then sets, with no compare short-cut. The CAM ends up holding the key.
- er_erase seen outside WAIT: ignored.
- rst asserted mid-operation: immediate return to IDLE and all strobes drop. A partially applied clear is not replayed.
- Clearing the erase RAM on reset is the erase RAM's own job; this block only relies on EMPTY_KEY.

Optional Feature:
- Macro: CAM_WRITE_CTRL_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT.
  - If er_erase has not arrived after TIMEOUT_CYCLES cycles, go to IDLE without touching the CAM.
  - Pulse output port err (1 bit, reset 0) for 1 cycle; done stays 0.
- Undefined:
  - No counter and no err port; WAIT holds indefinitely.

Decomposition:
- Shared package cam_pkg holds:
  - the state enum (IDLE, LOOKUP, WAIT, ERASE, WRITE);
  - the default DATA_WIDTH/ADDR_WIDTH constants;
  - EMPTY_KEY;
  - the erase-RAM response latency constant (2).
- No sub-module; a single FSM with its datapath registers.
- The timeout counter stays inline.

Test Plan:
- Reset, then req addr=1 data=0x5A into empty RAM -> er_write at cycle 1, cam_set with key 0x5A at cycle 4, no cam_clr, done at cycle 4.
- Then req addr=1 data=0x3C -> cam_clr with key 0x5A at cycle 4, cam_set with key 0x3C at cycle 5, done at cycle 5.
- Back-to-back requests with req_valid held high -> second accepted the cycle after done; req_ready=0 throughout busy.
- rst pulsed while in ERASE -> strobes low immediately, req_ready=1 the cycle after release, no cam_set issued.
- With CAM_WRITE_CTRL_TIMEOUT_EN, er_erase tied low -> err pulse after TIMEOUT_CYCLES=4 WAIT cycles, return to IDLE, no CAM strobes.
- Same key 0x77 written twice to addr=2 -> second request issues cam_clr 0x77 then cam_set 0x77.
